// File: rtl/busarb_pkg.sv
// Shared types and constants for the KS10 backplane bus arbiter.
// The BUSARB_TIMEOUT_EN build option is handled in bus_arbiter.sv.
package busarb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  // Master slot assignment on the backplane
  localparam int unsigned MST_CPU  = 0;
  localparam int unsigned MST_CSL  = 1;
  localparam int unsigned MST_UBA1 = 2;
  localparam int unsigned MST_UBA3 = 3;

  localparam int unsigned MaxReq = 8;

  // Reference round-robin pick: first requester after 'last', modulo nreq, as one-hot
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                input int unsigned       last,
                                                input int unsigned       nreq);
    logic [MaxReq-1:0] gnt;
    logic [2:0]        idx;
    logic              found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= nreq; i++) begin
      idx = 3'((last + i) % nreq);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/busarb_rrpick.sv
// Combinational round-robin picker: rotate requests so the slot after 'last' is
// bit 0, priority-encode the lowest set bit, then rotate the index back.
module busarb_rrpick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            any_o
);

  logic [NREQ-1:0] rot;
  logic [IdxW-1:0] src;
  logic [IdxW-1:0] off;

  // Rotate requests so the search starts just past the previous winner
  always_comb begin
    rot = '0;
    src = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      src    = IdxW'((32'(last_i) + 1 + i) % NREQ);
      rot[i] = req_i[src];
    end
  end

  // Lowest set rotated bit wins; map its offset back to a master index
  always_comb begin
    any_o = 1'b0;
    off   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any_o = 1'b1;
        off   = IdxW'(i);
      end
    end
    gnt_idx_o = IdxW'((32'(last_i) + 1 + 32'(off)) % NREQ);
    gnt_o     = '0;
    if (any_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// KS10 backplane bus arbiter: round-robin grant, one transaction at a time,
// registered strobe/ack. Define BUSARB_TIMEOUT_EN to enable the WAIT-state
// timeout that returns errO to the granted master after TOVAL cycles.
module bus_arbiter
  import busarb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TOVAL = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  reqI,
  input  logic [NREQ*36-1:0] addrI,
  input  logic [NREQ*36-1:0] dataI,
  output logic [NREQ-1:0]  ackO,
  output logic [NREQ-1:0]  errO,
  output logic [NREQ-1:0]  gntO,
  output logic             busREQO,
  output logic [35:0]      busADDRO,
  output logic [35:0]      busDATAO,
  input  logic             busACKI,
  input  logic [35:0]      busDATAI,
  output logic             busBUSY
);

  localparam int unsigned IdxW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("bus_arbiter: NREQ out of range");
  end
  if (TOVAL < 2) begin : g_bad_toval
    $error("bus_arbiter: TOVAL must be at least 2");
  end

  state_e          state_q;
  logic [IdxW-1:0] last_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic            bus_req_q;
  logic [35:0]     addr_q;
  logic [35:0]     data_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  logic [35:0]     win_addr;
  logic [35:0]     win_data;

  busarb_rrpick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rrpick (
    .req_i     (reqI),
    .last_i    (last_q),
    .gnt_o     (pick_gnt),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // One-hot mux of the candidate winner's address and data
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        win_addr = win_addr | addrI[36*i +: 36];
        win_data = win_data | dataI[36*i +: 36];
      end
    end
  end

`ifdef BUSARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TOVAL);
  logic [CntW-1:0] cnt_q;
  logic [NREQ-1:0] err_q;
`endif

  // Arbiter FSM with registered grant, strobe, ack and error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= IdxW'(NREQ - 1);
      gnt_q     <= '0;
      ack_q     <= '0;
      bus_req_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef BUSARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= '0;
`endif
    end else begin
      // Strobe and responses are single-cycle pulses
      ack_q     <= '0;
      bus_req_q <= 1'b0;
`ifdef BUSARB_TIMEOUT_EN
      err_q     <= '0;
`endif
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            gnt_q   <= pick_gnt;
            addr_q  <= win_addr;
            data_q  <= win_data;
            last_q  <= pick_idx;
            state_q <= StReq;
          end
        end
        StReq: begin
          bus_req_q <= 1'b1;
`ifdef BUSARB_TIMEOUT_EN
          cnt_q     <= '0;
`endif
          state_q   <= StWait;
        end
        StWait: begin
          // An ack on the expiry cycle takes precedence over the timeout
          if (busACKI) begin
            ack_q   <= gnt_q;
            state_q <= StDone;
          end
`ifdef BUSARB_TIMEOUT_EN
          else if (cnt_q == CntW'(TOVAL - 1)) begin
            err_q   <= gnt_q;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StDone: begin
          // Dead cycle: drop grant and bus drive before re-arbitrating
          gnt_q   <= '0;
          addr_q  <= '0;
          data_q  <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gntO     = gnt_q;
  assign ackO     = ack_q;
  assign busREQO  = bus_req_q;
  assign busADDRO = addr_q;
  assign busDATAO = data_q;
  assign busBUSY  = (state_q != StIdle);

`ifdef BUSARB_TIMEOUT_EN
  assign errO = err_q;
`else
  assign errO = '0;
`endif

  // Read data is shared by all masters; only the acked master samples it
  logic unused_busdata;
  assign unused_busdata = ^busDATAI;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NREQ = 4, TOVAL = 8).
module tb_bus_arbiter;
  import busarb_pkg::*;

  logic         clk;
  logic         rst;
  logic [3:0]   reqI;
  logic [143:0] addrI;
  logic [143:0] dataI;
  logic [3:0]   ackO;
  logic [3:0]   errO;
  logic [3:0]   gntO;
  logic         busREQO;
  logic [35:0]  busADDRO;
  logic [35:0]  busDATAO;
  logic         busACKI;
  logic [35:0]  busDATAI;
  logic         busBUSY;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(
    .NREQ  (4),
    .TOVAL (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .reqI     (reqI),
    .addrI    (addrI),
    .dataI    (dataI),
    .ackO     (ackO),
    .errO     (errO),
    .gntO     (gntO),
    .busREQO  (busREQO),
    .busADDRO (busADDRO),
    .busDATAO (busDATAO),
    .busACKI  (busACKI),
    .busDATAI (busDATAI),
    .busBUSY  (busBUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-assigned per-master address/data
  localparam logic [35:0] A0 = 36'o000000001234;
  localparam logic [35:0] A1 = 36'o200000000011;
  localparam logic [35:0] A2 = 36'o300000000022;
  localparam logic [35:0] A3 = 36'o400000000033;
  localparam logic [35:0] D0 = 36'o777000000000;
  localparam logic [35:0] D1 = 36'o111111111111;
  localparam logic [35:0] D2 = 36'o222222222222;
  localparam logic [35:0] D3 = 36'o333333333333;

  function automatic logic [3:0] oh(input int unsigned i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction from IDLE with requests pending; slave acks the cycle after the strobe
  task automatic txn(input string tag, input logic [3:0] eg, input logic [35:0] ea,
                     input logic [35:0] ed);
    tick();
    chk({tag, "_gnt"}, gntO, eg);
    chk({tag, "_busy"}, busBUSY, 1'b1);
    tick();
    chk({tag, "_strobe"}, busREQO, 1'b1);
    chk({tag, "_addr"}, busADDRO, ea);
    chk({tag, "_data"}, busDATAO, ed);
    tick();
    chk({tag, "_strobe_once"}, busREQO, 1'b0);
    chk({tag, "_noack_early"}, ackO, 4'b0000);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    chk({tag, "_ack"}, ackO, eg);
    chk({tag, "_noerr"}, errO, 4'b0000);
    tick();
    chk({tag, "_dead_gnt"}, gntO, 4'b0000);
    chk({tag, "_dead_ack"}, ackO, 4'b0000);
    chk({tag, "_dead_busy"}, busBUSY, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    reqI     = '0;
    addrI    = {A3, A2, A1, A0};
    dataI    = {D3, D2, D1, D0};
    busACKI  = 1'b0;
    busDATAI = 36'o525252525252;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_gnt", gntO, 4'b0000);
    chk("rst_ack", ackO, 4'b0000);
    chk("rst_err", errO, 4'b0000);
    chk("rst_req", busREQO, 1'b0);
    chk("rst_addr", busADDRO, 36'd0);
    chk("rst_data", busDATAO, 36'd0);
    chk("rst_busy", busBUSY, 1'b0);

    // Single request, cycle-by-cycle, with address frozen at grant
    reqI = oh(MST_CPU);
    tick();
    chk("single_gnt_c1", gntO, 4'b0001);
    chk("single_noreq_c1", busREQO, 1'b0);
    tick();
    chk("single_req_c2", busREQO, 1'b1);
    chk("single_addr_c2", busADDRO, A0);
    addrI[0 +: 36] = 36'o000000004321;
    tick();
    chk("single_addr_frozen", busADDRO, A0);
    chk("single_noack_c3", ackO, 4'b0000);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    chk("single_ack_c4", ackO, 4'b0001);
    reqI = '0;
    addrI[0 +: 36] = A0;
    tick();
    chk("single_gnt_c5", gntO, 4'b0000);
    chk("single_ack_c5", ackO, 4'b0000);
    chk("single_addr_c5", busADDRO, 36'd0);

    // Fairness from reset: all four requesting continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reqI = 4'b1111;
    txn("rr0", oh(MST_CPU), A0, D0);
    txn("rr1", oh(MST_CSL), A1, D1);
    txn("rr2", oh(MST_UBA1), A2, D2);
    txn("rr3", oh(MST_UBA3), A3, D3);
    txn("rr4", oh(MST_CPU), A0, D0);

    // Master 2 drops its request in WAIT; last winner was 0 so 2 wins over 3 and 0
    reqI = 4'b1101;
    tick();
    chk("drop_gnt", gntO, 4'b0100);
    tick();
    chk("drop_strobe", busREQO, 1'b1);
    reqI = 4'b1001;
    tick();
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    chk("drop_ack", ackO, 4'b0100);
    tick();
    chk("drop_dead", gntO, 4'b0000);
    txn("drop_next", 4'b1000, A3, D3);
    txn("drop_wrap", 4'b0001, A0, D0);
    reqI = '0;
    tick();

    // Reset in WAIT, then a late ack
    reqI = 4'b0010;
    tick();
    chk("rstw_gnt", gntO, 4'b0010);
    tick();
    chk("rstw_strobe", busREQO, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reqI = '0;
    chk("rstw_gnt0", gntO, 4'b0000);
    chk("rstw_busy0", busBUSY, 1'b0);
    chk("rstw_addr0", busADDRO, 36'd0);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    chk("rstw_late_ack", ackO, 4'b0000);
    chk("rstw_late_err", errO, 4'b0000);
    chk("rstw_late_busy", busBUSY, 1'b0);
    reqI = 4'b1111;
    txn("rstw_first", 4'b0001, A0, D0);
    reqI = '0;
    tick();

    // Unanswered cycle: master 0 alone (last = 0, so it still wins)
    reqI = 4'b0001;
    tick();
    chk("to_gnt", gntO, 4'b0001);
    tick();
    repeat (7) tick();
    chk("to_pre_err", errO, 4'b0000);
`ifdef BUSARB_TIMEOUT_EN
    tick();
    chk("to_err", errO, 4'b0001);
    chk("to_noack", ackO, 4'b0000);
    reqI = '0;
    tick();
    chk("to_err_once", errO, 4'b0000);
    chk("to_dead", gntO, 4'b0000);
    tick();

    // Ack on the expiry cycle wins over the timeout
    reqI = 4'b0001;
    tick();
    tick();
    repeat (7) tick();
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    chk("exp_ack", ackO, 4'b0001);
    chk("exp_noerr", errO, 4'b0000);
    reqI = '0;
    tick();
`else
    repeat (20) tick();
    chk("hold_gnt", gntO, 4'b0001);
    chk("hold_busy", busBUSY, 1'b1);
    chk("hold_noerr", errO, 4'b0000);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    chk("hold_ack", ackO, 4'b0001);
    chk("hold_ack_noerr", errO, 4'b0000);
    reqI = '0;
    tick();
`endif
    chk("end_idle", busBUSY, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
